// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch stage: datapath width, PC step, adder ops, fetch FSM states.
// FETCH_CTRL_MISALIGN_TRAP_EN adds the TRAP state to fetch_state_t.
package rv32i_pkg;

    localparam int DPW = 32;
    localparam logic [DPW-1:0] PC_STEP = DPW'(4);

    typedef enum logic {
        ADD_OP = 1'b0,
        SUB_OP = 1'b1
    } addsub_op_t;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        FS_RESET = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_TRAP  = 3'd4
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_REQ   = 2'd1,
        FS_WAIT  = 2'd2,
        FS_HOLD  = 2'd3
    } fetch_state_t;
`endif

endpackage

// File: rtl/adder_sub.sv
// Combinational add/subtract; op_i selects ADD_OP or SUB_OP, result wraps modulo 2^DATA_W.
module adder_sub
    import rv32i_pkg::*;
#(
    parameter int DATA_W = DPW
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              op_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = (op_i == logic'(SUB_OP)) ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/fetch_hold_reg.sv
// Capture register for a stalled instruction and its PC; clear wins over load.
module fetch_hold_reg
    import rv32i_pkg::*;
(
    input  logic           clk_i,
    input  logic           load_i,
    input  logic           clear_i,
    input  logic [31:0]    instr_i,
    input  logic [DPW-1:0] pc_i,
    output logic [31:0]    instr_o,
    output logic [DPW-1:0] pc_o
);

    logic [32+DPW-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= {instr_i, pc_i};
        end
    end

    assign instr_o = data_q[32+DPW-1:DPW];
    assign pc_o    = data_q[DPW-1:0];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns PCF, runs a single-outstanding req/gnt/rvalid fetch, applies redirects and stalls.
// FETCH_CTRL_MISALIGN_TRAP_EN enables the misaligned-target trap and the misalign_o port.
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [DPW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           stall_i,
    input  logic           br_taken_i,
    input  logic [DPW-1:0] br_target_i,
    output logic           imem_req_o,
    output logic [DPW-1:0] imem_addr_o,
    input  logic           imem_gnt_i,
    input  logic           imem_rvalid_i,
    input  logic [31:0]    imem_rdata_i,
    output logic [DPW-1:0] pcf_o,
    output logic [31:0]    instr_o,
    output logic           instr_valid_o,
    output logic [DPW-1:0] instr_pc_o,
    output logic           flush_d_o,
    output logic           flush_e_o
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    ,
    output logic           misalign_o
`endif
);

    fetch_state_t   state_q, state_d;
    logic [DPW-1:0] pcf_q, pcf_d;
    logic           kill_q, kill_d;
    logic [DPW-1:0] pc_inc;
    logic [DPW-1:0] tgt_aligned;
    logic           br_act, redirect;
    logic           hold_load, hold_clear;
    logic [31:0]    hold_instr;
    logic [DPW-1:0] hold_pc;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic           bad_tgt;
    logic           misalign_q;
`endif

    adder_sub #(.DATA_W(DPW)) u_pc_add (
        .a_i  (pcf_q),
        .b_i  (PC_STEP),
        .op_i (ADD_OP),
        .y_o  (pc_inc)
    );

    fetch_hold_reg u_hold (
        .clk_i   (clk_i),
        .load_i  (hold_load),
        .clear_i (hold_clear | ~rst_ni),
        .instr_i (imem_rdata_i),
        .pc_i    (pcf_q),
        .instr_o (hold_instr),
        .pc_o    (hold_pc)
    );

    assign tgt_aligned = br_target_i & ~DPW'(3);
    assign br_act      = br_taken_i && (state_q != FS_RESET);
    assign flush_d_o   = br_act;
    assign flush_e_o   = br_act;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    assign bad_tgt     = br_act && (br_target_i[1:0] != 2'b00);
    assign redirect    = br_act && !bad_tgt && (state_q != FS_TRAP);
    assign misalign_o  = misalign_q;
`else
    assign redirect    = br_act;
`endif
    assign imem_addr_o = pcf_o;

    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        kill_d        = kill_q;
        pcf_o         = pcf_q;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        instr_o       = '0;
        instr_pc_o    = pcf_q;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;

        case (state_q)
            FS_RESET: state_d = FS_REQ;
            FS_REQ: begin
                imem_req_o = 1'b1;
                // A grant coinciding with a redirect fetches a stale PC, so its response must be killed.
                if (imem_gnt_i) begin
                    state_d = FS_WAIT;
                    kill_d  = redirect;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_q || redirect) begin
                        state_d = FS_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        instr_valid_o = 1'b1;
                        instr_o       = imem_rdata_i;
                        if (stall_i) begin
                            hold_load = 1'b1;
                            state_d   = FS_HOLD;
                        end else begin
                            // Back-to-back: the next request goes out in the response cycle.
                            pcf_d      = pc_inc;
                            pcf_o      = pc_inc;
                            imem_req_o = 1'b1;
                            state_d    = imem_gnt_i ? FS_WAIT : FS_REQ;
                        end
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            FS_HOLD: begin
                instr_valid_o = 1'b1;
                instr_o       = hold_instr;
                instr_pc_o    = hold_pc;
                if (redirect || !stall_i) begin
                    hold_clear = 1'b1;
                    state_d    = FS_REQ;
                    pcf_d      = pc_inc;
                end
            end
            default: ;
        endcase

        if (redirect) begin
            pcf_d         = tgt_aligned;
            instr_valid_o = 1'b0;
            instr_o       = '0;
        end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        if (bad_tgt) begin
            state_d       = FS_TRAP;
            kill_d        = 1'b0;
            instr_valid_o = 1'b0;
            instr_o       = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= FS_RESET;
            pcf_q      <= RESET_PC;
            kill_q     <= 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            kill_q     <= kill_d;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            misalign_q <= misalign_q | (state_d == FS_TRAP);
`endif
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, stall/hold, redirects, grant back-pressure, reset, target alignment.
// Build with FETCH_CTRL_MISALIGN_TRAP_EN defined to exercise the misalignment trap instead of the silent alignment.
module tb_fetch_ctrl;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0, stall = 1'b0, br = 1'b0, gnt = 1'b0, rv = 1'b0;
    logic [31:0]    tgt = '0, rdata = '0;
    logic           req, ivalid, fl_d, fl_e;
    logic [DPW-1:0] addr, pcf, ipc;
    logic [31:0]    instr;
    logic [3:0]     ctl;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic           mis;
`endif
    int total = 0;
    int bad = 0;

    localparam logic [31:0] I0 = 32'h0000_0013, I1 = 32'h0010_0093, I2 = 32'h0020_0113;
    localparam logic [31:0] I3 = 32'h0030_0193, I4 = 32'hDEAD_BEEF, I5 = 32'hBAD0_0BAD;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .br_taken_i    (br),
        .br_target_i   (tgt),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rv),
        .imem_rdata_i  (rdata),
        .pcf_o         (pcf),
        .instr_o       (instr),
        .instr_valid_o (ivalid),
        .instr_pc_o    (ipc),
        .flush_d_o     (fl_d),
        .flush_e_o     (fl_e)
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        ,
        .misalign_o    (mis)
`endif
    );

    assign ctl = {req, ivalid, fl_d, fl_e};

    // Applies one cycle of inputs just after the rising edge, then lets combinational outputs settle.
    task automatic drive(input logic r, input logic g, input logic v, input logic [31:0] d,
                         input logic s, input logic b, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst_n = r; gnt = g; rv = v; rdata = d; stall = s; br = b; tgt = t;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 4'b0000); end
        total++; if (pcf !== 32'h0) begin bad++; $display("FAIL reset_pcf got=%h exp=%h", pcf, 32'h0); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
        total++; if (ipc !== 32'h0) begin bad++; $display("FAIL reset_ipc got=%h exp=%h", ipc, 32'h0); end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        total++; if (mis !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=%b", mis, 1'b0); end
`endif
        drive(1, 0, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL release_noreq got=%b exp=%b", ctl, 4'b0000); end
    endtask

    task automatic test_stream();
        drive(1, 1, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL stream_req0 got=%b exp=%b", ctl, 4'b1000); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL stream_addr0 got=%h exp=%h", addr, 32'h0); end
        drive(1, 1, 1, I0, 0, 0, 0);
        total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL stream_ctl1 got=%b exp=%b", ctl, 4'b1100); end
        total++; if (instr !== I0) begin bad++; $display("FAIL stream_instr0 got=%h exp=%h", instr, I0); end
        total++; if (ipc !== 32'h0) begin bad++; $display("FAIL stream_ipc0 got=%h exp=%h", ipc, 32'h0); end
        total++; if (addr !== 32'h4) begin bad++; $display("FAIL stream_addr4 got=%h exp=%h", addr, 32'h4); end
        drive(1, 1, 1, I1, 0, 0, 0);
        total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL stream_ctl2 got=%b exp=%b", ctl, 4'b1100); end
        total++; if (ipc !== 32'h4) begin bad++; $display("FAIL stream_ipc4 got=%h exp=%h", ipc, 32'h4); end
        total++; if (addr !== 32'h8) begin bad++; $display("FAIL stream_addr8 got=%h exp=%h", addr, 32'h8); end
    endtask

    task automatic test_stall();
        drive(1, 0, 1, I2, 1, 0, 0);
        total++; if (ctl !== 4'b0100) begin bad++; $display("FAIL stall_rsp_ctl got=%b exp=%b", ctl, 4'b0100); end
        total++; if (ipc !== 32'h8) begin bad++; $display("FAIL stall_rsp_ipc got=%h exp=%h", ipc, 32'h8); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0);
            total++; if (ctl !== 4'b0100) begin bad++; $display("FAIL hold_ctl%0d got=%b exp=%b", i, ctl, 4'b0100); end
            total++; if (ipc !== 32'h8) begin bad++; $display("FAIL hold_ipc%0d got=%h exp=%h", i, ipc, 32'h8); end
            total++; if (instr !== I2) begin bad++; $display("FAIL hold_instr%0d got=%h exp=%h", i, instr, I2); end
            total++; if (pcf !== 32'h8) begin bad++; $display("FAIL hold_pcf%0d got=%h exp=%h", i, pcf, 32'h8); end
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b0100) begin bad++; $display("FAIL unstall_ctl got=%b exp=%b", ctl, 4'b0100); end
        total++; if (ipc !== 32'h8) begin bad++; $display("FAIL unstall_ipc got=%h exp=%h", ipc, 32'h8); end
        drive(1, 1, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL after_stall_req got=%b exp=%b", ctl, 4'b1000); end
        total++; if (addr !== 32'hC) begin bad++; $display("FAIL after_stall_addr got=%h exp=%h", addr, 32'hC); end
        drive(1, 1, 1, I3, 0, 0, 0);
        total++; if (ipc !== 32'hC) begin bad++; $display("FAIL resume_ipc got=%h exp=%h", ipc, 32'hC); end
        total++; if (addr !== 32'h10) begin bad++; $display("FAIL resume_addr got=%h exp=%h", addr, 32'h10); end
    endtask

    task automatic test_redirect_wait();
        drive(1, 0, 0, 0, 0, 1, 32'h100);
        total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL redir_flush got=%b exp=%b", ctl, 4'b0011); end
        drive(1, 0, 1, I4, 0, 0, 0);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL redir_drop got=%b exp=%b", ctl, 4'b0000); end
        drive(1, 0, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL redir_req got=%b exp=%b", ctl, 4'b1000); end
        total++; if (addr !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=%h", addr, 32'h100); end
    endtask

    task automatic test_gnt_low();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL gntlow_ctl%0d got=%b exp=%b", i, ctl, 4'b1000); end
            total++; if (addr !== 32'h100) begin bad++; $display("FAIL gntlow_addr%0d got=%h exp=%h", i, addr, 32'h100); end
        end
        drive(1, 0, 0, 0, 0, 1, 32'h200);
        total++; if (ctl !== 4'b1011) begin bad++; $display("FAIL gntlow_br_ctl got=%b exp=%b", ctl, 4'b1011); end
        total++; if (addr !== 32'h100) begin bad++; $display("FAIL gntlow_br_addr got=%h exp=%h", addr, 32'h100); end
        drive(1, 1, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL retarget_ctl got=%b exp=%b", ctl, 4'b1000); end
        total++; if (addr !== 32'h200) begin bad++; $display("FAIL retarget_addr got=%h exp=%h", addr, 32'h200); end
    endtask

    task automatic test_reset_mid_wait();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, I5, 0, 0, 0);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL rstwait_ctl got=%b exp=%b", ctl, 4'b0000); end
        total++; if (pcf !== 32'h0) begin bad++; $display("FAIL rstwait_pcf got=%h exp=%h", pcf, 32'h0); end
        drive(1, 0, 1, I5, 0, 0, 0);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL late_rvalid got=%b exp=%b", ctl, 4'b0000); end
        drive(1, 1, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL rst_first_req got=%b exp=%b", ctl, 4'b1000); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL rst_first_addr got=%h exp=%h", addr, 32'h0); end
    endtask

    task automatic test_misalign();
        drive(1, 0, 0, 0, 0, 1, 32'h102);
        total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL mis_flush got=%b exp=%b", ctl, 4'b0011); end
        drive(1, 0, 1, I4, 0, 0, 0);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL mis_drop got=%b exp=%b", ctl, 4'b0000); end
        drive(1, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL trap_noreq got=%b exp=%b", ctl, 4'b0000); end
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL trap_mis got=%b exp=%b", mis, 1'b1); end
        drive(1, 1, 0, 0, 0, 0, 0);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL trap_sticky_ctl got=%b exp=%b", ctl, 4'b0000); end
        total++; if (mis !== 1'b1) begin bad++; $display("FAIL trap_sticky_mis got=%b exp=%b", mis, 1'b1); end
`else
        total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL align_req got=%b exp=%b", ctl, 4'b1000); end
        total++; if (addr !== 32'h100) begin bad++; $display("FAIL align_addr got=%h exp=%h", addr, 32'h100); end
        total++; if (pcf !== 32'h100) begin bad++; $display("FAIL align_pcf got=%h exp=%h", pcf, 32'h100); end
`endif
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        total++; if (mis !== 1'b0) begin bad++; $display("FAIL wrap_mis_clear got=%b exp=%b", mis, 1'b0); end
`endif
        drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        total++; if (ctl !== 4'b1011) begin bad++; $display("FAIL wrap_br_ctl got=%b exp=%b", ctl, 4'b1011); end
        drive(1, 1, 0, 0, 0, 0, 0);
        total++; if (addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top_addr got=%h exp=%h", addr, 32'hFFFF_FFFC); end
        drive(1, 1, 1, I1, 0, 0, 0);
        total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL wrap_ctl got=%b exp=%b", ctl, 4'b1100); end
        total++; if (ipc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_ipc got=%h exp=%h", ipc, 32'hFFFF_FFFC); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=%h", addr, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_gnt_low();
        test_reset_mid_wait();
        test_misalign();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
